// File: rtl/sa_seq_ctrl_pkg.sv
// rtl/sa_seq_ctrl_pkg.sv - systolic-array sequencer state encoding and derived sizes
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_FEED     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } sa_state_e;

    function automatic int n_pix(input int w, input int h);
        return w * h;
    endfunction

    function automatic int n_k(input int w, input int h, input int c);
        return w * h * c;
    endfunction

    function automatic int feed_len(input int w, input int h, input int port);
        return w * h + port - 1;
    endfunction

    // Width able to index 0..v-1, never narrower than one bit.
    function automatic int bits_for(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// rtl/sa_seq_ctrl_if.sv - control strobes and buffer read bus of the sequencer
interface sa_seq_ctrl_if #(
    parameter int WIDTH   = 128,
    parameter int HEIGHT  = 128,
    parameter int CHANNEL = 3,
    parameter int PORT    = 27
);
    import sa_ctrl_pkg::*;

    localparam int K_AW   = bits_for(n_k(WIDTH, HEIGHT, CHANNEL));
    localparam int PIX_AW = bits_for(n_pix(WIDTH, HEIGHT));

    logic              i_start;
    logic              i_stall;
    logic              i_of_valid;
    logic              o_k_rd_en;
    logic [K_AW-1:0]   o_k_rd_addr;
    logic              o_if_rd_en;
    logic [PIX_AW-1:0] o_if_pix_addr;
    logic [PORT-1:0]   o_lane_valid;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport master (
        output i_start, i_stall, i_of_valid,
        input  o_k_rd_en, o_k_rd_addr, o_if_rd_en, o_if_pix_addr,
               o_lane_valid, o_busy, o_done, o_err
    );

    modport slave (
        input  i_start, i_stall, i_of_valid,
        output o_k_rd_en, o_k_rd_addr, o_if_rd_en, o_if_pix_addr,
               o_lane_valid, o_busy, o_done, o_err
    );

endinterface

// File: rtl/sa_seq_ctrl_skew_mask.sv
// rtl/sa_seq_ctrl_skew_mask.sv - diagonal lane-valid mask: lane j live when j<=i and i-j<N_PIX
module sa_skew_mask #(
    parameter int PORT  = 27,
    parameter int N_PIX = 16384,
    parameter int CW    = 15
) (
    input  logic [CW-1:0]   i,
    input  logic            active,
    output logic [PORT-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int j = 0; j < PORT; j++) begin
            if (active && (j <= int'(i)) && ((int'(i) - j) < N_PIX)) begin
                mask[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sa_seq_ctrl.sv
// rtl/sa_seq_ctrl.sv - layer sequencer: kernel prefetch, skewed im2col feed, output drain
// Optional drain watchdog enabled by defining SA_SEQ_WATCHDOG_EN.
module sa_seq_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int WIDTH   = 128,
    parameter int HEIGHT  = 128,
    parameter int CHANNEL = 3,
    parameter int PORT    = 27,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    sa_seq_ctrl_if.slave bus
);

    localparam int N_PIX    = n_pix(WIDTH, HEIGHT);
    localparam int N_K      = n_k(WIDTH, HEIGHT, CHANNEL);
    localparam int FEED_LEN = feed_len(WIDTH, HEIGHT, PORT);
    localparam int K_AW     = bits_for(N_K);
    localparam int PIX_AW   = bits_for(N_PIX);
    localparam int FEED_CW  = bits_for(FEED_LEN + 1);
    localparam int OF_CW    = bits_for(N_K + 1);

    sa_state_e          state_q, state_d;
    logic [K_AW-1:0]    k_q;
    logic [FEED_CW-1:0] i_q;
    logic [OF_CW-1:0]   of_q, of_nxt;
    logic               pf_go, feed_go, pf_last, feed_last, of_inc, of_full, wd_hit;

    logic               k_rd_en_d, if_rd_en_d, busy_d, done_d;
    logic [K_AW-1:0]    k_rd_addr_d;
    logic [PIX_AW-1:0]  pix_addr_d;
    logic [PORT-1:0]    lane_d;

    assign pf_go     = (state_q == ST_PREFETCH) && !bus.i_stall;
    assign feed_go   = (state_q == ST_FEED) && !bus.i_stall;
    assign pf_last   = (k_q == K_AW'(N_K - 1));
    assign feed_last = (i_q == FEED_CW'(FEED_LEN - 1));

    // Output-feature pulses may arrive while the feed is still running; saturate at N_K.
    assign of_inc = bus.i_of_valid && (of_q != OF_CW'(N_K)) &&
                    ((state_q == ST_PREFETCH) || (state_q == ST_FEED) || (state_q == ST_DRAIN));
    assign of_nxt  = of_inc ? (of_q + OF_CW'(1)) : of_q;
    assign of_full = (of_nxt == OF_CW'(N_K));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.i_start) state_d = ST_PREFETCH;
            ST_PREFETCH: if (pf_go && pf_last) state_d = ST_FEED;
            ST_FEED:     if (feed_go && feed_last) state_d = ST_DRAIN;
            ST_DRAIN:    if (of_full || wd_hit) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q  <= '0;
            i_q  <= '0;
            of_q <= '0;
        end else if (state_q == ST_IDLE) begin
            k_q  <= '0;
            i_q  <= '0;
            of_q <= '0;
        end else begin
            if (pf_go && !pf_last)     k_q <= k_q + K_AW'(1);
            if (feed_go && !feed_last) i_q <= i_q + FEED_CW'(1);
            of_q <= of_nxt;
        end
    end

    sa_skew_mask #(
        .PORT  (PORT),
        .N_PIX (N_PIX),
        .CW    (FEED_CW)
    ) u_skew (
        .i      (i_q),
        .active (feed_go),
        .mask   (lane_d)
    );

    always_comb begin
        k_rd_en_d   = pf_go;
        k_rd_addr_d = pf_go ? (K_AW'(N_K - 1) - k_q) : '0;
        if_rd_en_d  = feed_go && (i_q < FEED_CW'(N_PIX));
        pix_addr_d  = if_rd_en_d ? i_q[PIX_AW-1:0] : '0;
        busy_d      = (state_q != ST_IDLE);
        done_d      = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.o_k_rd_en     <= 1'b0;
            bus.o_k_rd_addr   <= '0;
            bus.o_if_rd_en    <= 1'b0;
            bus.o_if_pix_addr <= '0;
            bus.o_lane_valid  <= '0;
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
        end else begin
            bus.o_k_rd_en     <= k_rd_en_d;
            bus.o_k_rd_addr   <= k_rd_addr_d;
            bus.o_if_rd_en    <= if_rd_en_d;
            bus.o_if_pix_addr <= pix_addr_d;
            bus.o_lane_valid  <= lane_d;
            bus.o_busy        <= busy_d;
            bus.o_done        <= done_d;
        end
    end

`ifdef SA_SEQ_WATCHDOG_EN
    localparam int WD_CW = bits_for(TIMEOUT + 1);

    logic [WD_CW-1:0] wd_q;
    logic             wd_to_q;

    // Idle cycles in DRAIN since the last output pulse; the error sticks until a new run.
    assign wd_hit = (state_q == ST_DRAIN) && !bus.i_of_valid && (wd_q == WD_CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            wd_to_q <= 1'b0;
            bus.o_err <= 1'b0;
        end else begin
            if (state_q != ST_DRAIN || bus.i_of_valid) wd_q <= '0;
            else if (!wd_hit)                          wd_q <= wd_q + WD_CW'(1);
            if (state_q == ST_IDLE && bus.i_start)     wd_to_q <= 1'b0;
            else if (wd_hit && !of_full)               wd_to_q <= 1'b1;
            bus.o_err <= wd_to_q;
        end
    end
`else
    assign wd_hit    = 1'b0;
    assign bus.o_err = 1'b0;
`endif

endmodule
